// File: rtl/systolic_feed_ctrl_if.sv
// Upstream vector stream into systolic_feed_ctrl: valid/ready handshake plus an N-lane vector.
interface systolic_feed_ctrl_if #(
  parameter int unsigned N          = 16,
  parameter int unsigned DATA_WIDTH = 16
);
  logic                    in_valid;
  logic                    in_ready;
  logic [N*DATA_WIDTH-1:0] in_data;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/systolic_feed_ctrl.sv
// Feeds one tile of N-lane vectors into a skew-register stage, then drains it by N-1 cycles.
// Optional macro SYSTOLIC_FEED_CTRL_STALL_CNT_EN adds the 32-bit stall_cnt output.
module systolic_feed_ctrl #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned N          = 16,
  parameter int unsigned LEN_WIDTH  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [LEN_WIDTH-1:0]    len,
  systolic_feed_ctrl_if.slave     up,
  output logic                    skew_en,
  output logic [N*DATA_WIDTH-1:0] feed_data,
  output logic [N-1:0]            lane_valid,
  output logic                    busy,
  output logic                    done
`ifdef SYSTOLIC_FEED_CTRL_STALL_CNT_EN
  ,
  output logic [31:0]             stall_cnt
`endif
);

  localparam int unsigned VW = N * DATA_WIDTH;
  // Drain counter runs 0..N-2; keep at least one bit so N<=2 still elaborates.
  localparam int unsigned DW = (N > 2) ? $clog2(N - 1) : 1;
  localparam logic [DW-1:0] DRAIN_LAST = DW'((N > 1) ? (N - 2) : 0);

  typedef enum logic [1:0] {IDLE, FEED, DRAIN, DONE} state_e;

  state_e               state_q, state_d;
  logic [LEN_WIDTH-1:0] cnt_q, cnt_d;
  logic [LEN_WIDTH-1:0] len_q, len_d;
  logic [DW-1:0]        drain_q, drain_d;
  logic                 in_ready_c;
  logic                 skew_en_c;
  logic                 accept_c;
  logic [VW-1:0]        feed_c;
`ifdef SYSTOLIC_FEED_CTRL_STALL_CNT_EN
  logic [31:0]          stall_q, stall_d;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      len_q   <= '0;
      drain_q <= '0;
`ifdef SYSTOLIC_FEED_CTRL_STALL_CNT_EN
      stall_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      drain_q <= drain_d;
`ifdef SYSTOLIC_FEED_CTRL_STALL_CNT_EN
      stall_q <= stall_d;
`endif
    end
  end

  // Next-state and datapath steering.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    len_d      = len_q;
    drain_d    = drain_q;
    in_ready_c = 1'b0;
    skew_en_c  = 1'b0;
    accept_c   = 1'b0;
    feed_c     = '0;
`ifdef SYSTOLIC_FEED_CTRL_STALL_CNT_EN
    stall_d    = stall_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
`ifdef SYSTOLIC_FEED_CTRL_STALL_CNT_EN
          stall_d = '0;
`endif
          if (len != '0) begin
            len_d   = len;
            cnt_d   = '0;
            state_d = FEED;
          end else begin
            state_d = DONE;
          end
        end
      end
      FEED: begin
        in_ready_c = 1'b1;
        if (up.in_valid) begin
          accept_c  = 1'b1;
          skew_en_c = 1'b1;
          feed_c    = up.in_data;
          cnt_d     = cnt_q + LEN_WIDTH'(1);
          // Compare before incrementing so len = all-ones never wraps the counter.
          if (cnt_q == len_q - LEN_WIDTH'(1)) begin
            drain_d = '0;
            state_d = (N > 1) ? DRAIN : DONE;
          end
        end else begin
`ifdef SYSTOLIC_FEED_CTRL_STALL_CNT_EN
          if (stall_q != '1) stall_d = stall_q + 32'd1;
`endif
        end
      end
      DRAIN: begin
        skew_en_c = 1'b1;
        if (drain_q == DRAIN_LAST) state_d = DONE;
        else                       drain_d = drain_q + DW'(1);
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Reset forces every output low even before the state register has cleared.
  assign up.in_ready    = in_ready_c & ~rst;
  assign skew_en        = skew_en_c & ~rst;
  assign feed_data      = rst ? '0 : feed_c;
  assign lane_valid[0]  = accept_c & ~rst;
  assign busy           = ~rst & (state_q != IDLE);
  assign done           = ~rst & (state_q == DONE);
`ifdef SYSTOLIC_FEED_CTRL_STALL_CNT_EN
  assign stall_cnt      = stall_q;
`endif

  // Lane i validity trails lane 0 by i skew-enabled cycles, mirroring the skew stage.
  if (N > 1) begin : g_chain
    logic [N-2:0] lv_q, lv_d;

    always_comb begin
      lv_d = lv_q;
      if (skew_en_c) begin
        lv_d[0] = accept_c;
        for (int i = 1; i < int'(N) - 1; i++) lv_d[i] = lv_q[i-1];
      end
    end

    always_ff @(posedge clk) begin
      if (rst) lv_q <= '0;
      else     lv_q <= lv_d;
    end

    assign lane_valid[N-1:1] = rst ? '0 : lv_q;
  end

endmodule

// File: tb/tb_systolic_feed_ctrl.sv
// Directed bench for systolic_feed_ctrl: N=4 default, N=4/LEN_WIDTH=4 wrap boundary, N=1 build.
module tb_systolic_feed_ctrl;

  logic        clk = 1'b0;
  logic        tb_rst;
  logic        tb_start;
  logic [15:0] tb_len;
  logic        tb_valid;
  logic [63:0] tb_data;
  int          tb_sel;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  systolic_feed_ctrl_if #(.N(4), .DATA_WIDTH(16)) if0 ();
  systolic_feed_ctrl_if #(.N(4), .DATA_WIDTH(16)) if1 ();
  systolic_feed_ctrl_if #(.N(1), .DATA_WIDTH(16)) if2 ();

  assign if0.in_valid = tb_valid;
  assign if0.in_data  = tb_data;
  assign if1.in_valid = tb_valid;
  assign if1.in_data  = tb_data;
  assign if2.in_valid = tb_valid;
  assign if2.in_data  = tb_data[15:0];

  logic        skew0, busy0, done0, skew1, busy1, done1, skew2, busy2, done2;
  logic [63:0] fd0, fd1;
  logic [15:0] fd2;
  logic [3:0]  lv0, lv1;
  logic [0:0]  lv2;
`ifdef SYSTOLIC_FEED_CTRL_STALL_CNT_EN
  logic [31:0] stall0, stall1, stall2;
`endif

  systolic_feed_ctrl #(.DATA_WIDTH(16), .N(4), .LEN_WIDTH(16)) dut0 (
    .clk(clk), .rst(tb_rst), .start(tb_start & (tb_sel == 0)), .len(tb_len), .up(if0),
    .skew_en(skew0), .feed_data(fd0), .lane_valid(lv0), .busy(busy0), .done(done0)
`ifdef SYSTOLIC_FEED_CTRL_STALL_CNT_EN
    , .stall_cnt(stall0)
`endif
  );

  systolic_feed_ctrl #(.DATA_WIDTH(16), .N(4), .LEN_WIDTH(4)) dut1 (
    .clk(clk), .rst(tb_rst), .start(tb_start & (tb_sel == 1)), .len(tb_len[3:0]), .up(if1),
    .skew_en(skew1), .feed_data(fd1), .lane_valid(lv1), .busy(busy1), .done(done1)
`ifdef SYSTOLIC_FEED_CTRL_STALL_CNT_EN
    , .stall_cnt(stall1)
`endif
  );

  systolic_feed_ctrl #(.DATA_WIDTH(16), .N(1), .LEN_WIDTH(16)) dut2 (
    .clk(clk), .rst(tb_rst), .start(tb_start & (tb_sel == 2)), .len(tb_len), .up(if2),
    .skew_en(skew2), .feed_data(fd2), .lane_valid(lv2), .busy(busy2), .done(done2)
`ifdef SYSTOLIC_FEED_CTRL_STALL_CNT_EN
    , .stall_cnt(stall2)
`endif
  );

  // Observation mux over the selected DUT.
  logic        s_ready, s_skew, s_busy, s_done;
  logic [63:0] s_fd;
  logic [3:0]  s_lv;
  always_comb begin
    s_ready = if0.in_ready; s_skew = skew0; s_busy = busy0; s_done = done0;
    s_fd    = fd0;          s_lv   = lv0;
    if (tb_sel == 1) begin
      s_ready = if1.in_ready; s_skew = skew1; s_busy = busy1; s_done = done1;
      s_fd    = fd1;          s_lv   = lv1;
    end else if (tb_sel == 2) begin
      s_ready = if2.in_ready; s_skew = skew2; s_busy = busy2; s_done = done2;
      s_fd    = 64'(fd2);     s_lv   = {3'b000, lv2};
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Per-tile observations, cycle 0 being the cycle start is driven.
  int          n_ready, n_skew, n_lv3, n_done, n_busy, done_at;
  logic [63:0] skew_pat;
  logic [5:0]  post_rst;
  logic [3:0]  lv_hist [64];
  logic [63:0] fd_hist [64];

  function automatic logic [63:0] vec(input int k);
    return {16'(k * 4 + 3), 16'(k * 4 + 2), 16'(k * 4 + 1), 16'(k * 4)};
  endfunction

  task automatic run_tile(input int sel, input logic [15:0] l, input logic [63:0] vpat,
                          input logic [63:0] spat, input int rst_at, input int ncyc);
    tb_sel = sel;
    n_ready = 0; n_skew = 0; n_lv3 = 0; n_done = 0; n_busy = 0; done_at = -1;
    skew_pat = '0; post_rst = '1;
    for (int k = 0; k < ncyc; k++) begin
      tb_start = spat[k];
      tb_len   = l;
      tb_valid = (k > 0) ? vpat[k-1] : 1'b0;
      tb_data  = vec(k);
      tb_rst   = (k == rst_at);
      #1;
      lv_hist[k]  = s_lv;
      fd_hist[k]  = s_fd;
      skew_pat[k] = s_skew;
      n_ready += int'(s_ready);
      n_skew  += int'(s_skew);
      n_lv3   += int'(s_lv[3]);
      n_busy  += int'(s_busy);
      if (s_done) begin
        n_done++;
        if (done_at < 0) done_at = k;
      end
      if (k == rst_at + 1) post_rst = {s_ready, s_skew, |s_fd, |s_lv, s_busy, s_done};
      @(posedge clk);
      #2;
    end
    tb_start = 1'b0; tb_valid = 1'b0; tb_rst = 1'b0; tb_data = '0;
  endtask

  initial begin
    tb_sel = 0; tb_start = 1'b0; tb_len = '0; tb_valid = 1'b1; tb_data = vec(9); tb_rst = 1'b1;
    @(posedge clk); #2;
    @(posedge clk); #1;
    chk("rst_in_ready",   64'(if0.in_ready), 64'd0);
    chk("rst_skew_en",    64'(skew0), 64'd0);
    chk("rst_feed_data",  fd0, 64'd0);
    chk("rst_lane_valid", 64'(lv0), 64'd0);
    chk("rst_busy_done",  64'({busy0, done0}), 64'd0);
    tb_rst = 1'b0; tb_valid = 1'b0;
    @(posedge clk); #2;
    chk("post_rst_idle",  64'({if0.in_ready, skew0, busy0, done0, lv0}), 64'd0);

    // len=3, no stalls
    run_tile(0, 16'd3, '1, 64'h1, -1, 10);
    chk("b_in_ready_cycles", 64'(n_ready), 64'd3);
    chk("b_skew_pattern",    skew_pat, 64'h7E);
    chk("b_lane3_cycles",    64'(n_lv3), 64'd3);
    chk("b_done_at",         64'(done_at), 64'd7);
    chk("b_done_count",      64'(n_done), 64'd1);
    chk("b_busy_cycles",     64'(n_busy), 64'd7);
    chk("b_feed_first",      fd_hist[1], 64'h0007_0006_0005_0004);
    chk("b_feed_drain",      fd_hist[4], 64'd0);
    chk("b_lv_feed3",        64'(lv_hist[3]), 64'h7);
    chk("b_lv_drain1",       64'(lv_hist[4]), 64'hE);
    chk("b_lv_drain3",       64'(lv_hist[6]), 64'h8);

    // len=2, valid pattern 1,0,0,1
    run_tile(0, 16'd2, 64'b1001, 64'h1, -1, 11);
    chk("c_skew_pattern", skew_pat, 64'hF2);
    chk("c_stall_feed0",  fd_hist[2], 64'd0);
    chk("c_lv_stall1",    64'(lv_hist[2]), 64'h2);
    chk("c_lv_stall2",    64'(lv_hist[3]), 64'h2);
    chk("c_lv_resume",    64'(lv_hist[4]), 64'h3);
    chk("c_feed_second",  fd_hist[4], 64'h0013_0012_0011_0010);
    chk("c_done_at",      64'(done_at), 64'd8);
`ifdef SYSTOLIC_FEED_CTRL_STALL_CNT_EN
    chk("c_stall_cnt",    64'(stall0), 64'd2);
`endif

    // len=0
    run_tile(0, 16'd0, '1, 64'h1, -1, 4);
    chk("d_done_at",   64'(done_at), 64'd1);
    chk("d_busy",      64'(n_busy), 64'd1);
    chk("d_no_ready",  64'(n_ready), 64'd0);
    chk("d_no_skew",   64'(n_skew), 64'd0);

    // reset in the second drain cycle, then a fresh len=1 tile
    run_tile(0, 16'd3, '1, 64'h1, 5, 10);
    chk("e_post_rst_outs", 64'(post_rst), 64'd0);
    chk("e_no_done",       64'(n_done), 64'd0);
    run_tile(0, 16'd1, '1, 64'h1, -1, 8);
    chk("e_fresh_lv_first", 64'(lv_hist[1]), 64'h1);
    chk("e_fresh_lv_last",  64'(lv_hist[4]), 64'h8);
    chk("e_fresh_done_at",  64'(done_at), 64'd5);

    // start pulsed again while busy
    run_tile(0, 16'd2, '1, 64'h25, -1, 12);
    chk("f_done_count", 64'(n_done), 64'd1);
    chk("f_done_at",    64'(done_at), 64'd6);
    chk("f_in_ready",   64'(n_ready), 64'd2);

    // LEN_WIDTH=4, len=15 runs to completion without wrapping
    run_tile(1, 16'd15, '1, 64'h1, -1, 22);
    chk("g_in_ready", 64'(n_ready), 64'd15);
    chk("g_skew",     64'(n_skew), 64'd18);
    chk("g_done_at",  64'(done_at), 64'd19);
    chk("g_done_cnt", 64'(n_done), 64'd1);

    // N=1, len=2: no drain
    run_tile(2, 16'd2, '1, 64'h1, -1, 6);
    chk("h_skew_pattern", skew_pat, 64'h6);
    chk("h_done_at",      64'(done_at), 64'd3);
    chk("h_in_ready",     64'(n_ready), 64'd2);
    chk("h_lane0",        64'(lv_hist[1]), 64'h1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
